f_divider_back: RTL and testbench

Back end of the floating-point divider: takes the unnormalised exponent, 108-bit unrounded quotient and exception bits from `f_divider_front`, then normalises, denormalises, rounds and packs an IEEE-754 result with all five exception flags. It is a 3-stage stallable pipeline between the divider front end and FPU writeback. It shares the `a_wait`/`flush`/`info[0]`-valid conventions of the other FPU stages.

---
 rtl/f_divider_back_pkg.sv | 22 ++
 rtl/f_divider_back_lzc_frac.sv | 21 ++
 rtl/f_divider_back.sv | 208 ++++++++++++++++++++
 tb/tb_f_divider_back.sv | 345 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/f_divider_back_pkg.sv
// Shared FPU definitions for the divider back end.
// Holds the rounding-mode encoding, the exception-flag bit positions
// within the 5-bit flag vector, and the double-precision default NaN.
package f_divider_back_pkg;

  typedef enum logic [1:0] {
    RND_NE = 2'd0,  // round to nearest, ties to even
    RND_Z  = 2'd1,  // toward zero
    RND_P  = 2'd2,  // toward +inf
    RND_M  = 2'd3   // toward -inf
  } rmode_e;

  localparam int FLAG_W         = 5;
  localparam int FLAG_INVALID   = 4;
  localparam int FLAG_DIVBYZERO = 3;
  localparam int FLAG_OVERFLOW  = 2;
  localparam int FLAG_UNDERFLOW = 1;
  localparam int FLAG_INEXACT   = 0;

  localparam logic [63:0] SPEF_DNAN_D = 64'h7FF7_FFFF_FFFF_FFFF;

endpackage

// File: rtl/f_divider_back_lzc_frac.sv
// lzc_frac: parameterised leading-zero counter.
// Ports:
//   data_i  in  WIDTH   value to scan
//   lzc_o   out CNT_W   number of leading zeros (WIDTH when data_i == 0)
module lzc_frac #(
  parameter int WIDTH = 108,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic [WIDTH-1:0] data_i,
  output logic [CNT_W-1:0] lzc_o
);

  // Ascending scan: the highest set bit is the last one to write.
  always_comb begin
    lzc_o = CNT_W'(WIDTH);
    for (int i = 0; i < WIDTH; i++) begin
      if (data_i[i]) lzc_o = CNT_W'(WIDTH - 1 - i);
    end
  end

endmodule

// File: rtl/f_divider_back.sv
// f_divider_back: normalise / denormalise / round / pack stage of the FP
// divider. Three-stage stallable pipeline; info[0] is the valid bit.
// Ports:
//   clk, reset (sync, active-high), a_wait (downstream stall), flush
//   rmode, in_sign, in_exp, in_frac, in_info, in_invalid, in_divbyzero : input
//   stall_out : mirrors a_wait
//   result, info_out, flags {inv, dbz, ovf, unf, inx} : registered outputs
module f_divider_back
  import f_divider_back_pkg::*;
#(
  parameter int info_width = 1,
  parameter int exp_width  = 11,
  parameter int frac_width = 52
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            a_wait,
  input  logic                            flush,
  input  logic [1:0]                      rmode,
  input  logic                            in_sign,
  input  logic signed [exp_width+1:0]     in_exp,
  input  logic [2*frac_width+3:0]         in_frac,
  input  logic [info_width-1:0]           in_info,
  input  logic                            in_invalid,
  input  logic                            in_divbyzero,
  output logic                            stall_out,
  output logic [exp_width+frac_width:0]   result,
  output logic [info_width-1:0]           info_out,
  output logic [FLAG_W-1:0]               flags
);

  localparam int QW     = 2 * frac_width + 4;
  localparam int EW     = exp_width + 3;
  localparam int MW     = frac_width + 1;
  localparam int RW     = 1 + exp_width + frac_width;
  localparam int LZW    = $clog2(QW + 1);
  localparam int SH_MAX = frac_width + 3;
  localparam int SHW    = $clog2(SH_MAX + 1);

  localparam logic signed [EW-1:0] EXP_ZERO = '0;
  localparam logic signed [EW-1:0] EXP_ONE  = EW'(1);
  localparam logic signed [EW-1:0] EXP_TWO  = EW'(2);
  localparam logic signed [EW-1:0] EXP_OVF  = EW'((2 ** exp_width) - 1);
  localparam logic signed [EW-1:0] SH_SAT   = EW'(SH_MAX);
  localparam logic [RW-1:0] DNAN = {1'b0, {exp_width{1'b1}}, 1'b0, {(frac_width-1){1'b1}}};

  function automatic logic round_inc(input logic [1:0] rm, input logic sign,
                                     input logic lsb, input logic g, input logic s);
    logic inc;
    case (rmode_e'(rm))
      RND_NE:  inc = g & (s | lsb);
      RND_Z:   inc = 1'b0;
      RND_P:   inc = (g | s) & ~sign;
      default: inc = (g | s) & sign;
    endcase
    return inc;
  endfunction

  // Overflow saturates to infinity only when rounding away from zero.
  function automatic logic ovf_to_inf(input logic [1:0] rm, input logic sign);
    logic inf;
    case (rmode_e'(rm))
      RND_NE:  inf = 1'b1;
      RND_Z:   inf = 1'b0;
      RND_P:   inf = ~sign;
      default: inf = sign;
    endcase
    return inf;
  endfunction

  assign stall_out = a_wait;

  // ---------------- stage 1: normalise ----------------
  logic [LZW-1:0]         lz;
  logic signed [EW-1:0]   exp_n;

  lzc_frac #(.WIDTH(QW), .CNT_W(LZW)) u_lzc (
    .data_i (in_frac),
    .lzc_o  (lz)
  );

  // e_n = in_exp + (p - 105) with p = 107 - lz
  assign exp_n = $signed({{2{in_exp[exp_width+1]}}, in_exp}) + EXP_TWO
               - $signed({{(EW-LZW){1'b0}}, lz});

  logic                   sign_p0, inv_p0, dbz_p0, zero_p0;
  logic [1:0]             rmode_p0;
  logic signed [EW-1:0]   exp_p0;
  logic [QW-1:0]          frac_p0;
  logic [info_width-1:0]  info_p0;

  always_ff @(posedge clk) begin
    if (reset) begin
      sign_p0 <= 1'b0; inv_p0 <= 1'b0; dbz_p0 <= 1'b0; zero_p0 <= 1'b0;
      rmode_p0 <= '0; exp_p0 <= '0; frac_p0 <= '0; info_p0 <= '0;
    end else begin
      if (!a_wait) begin
        sign_p0  <= in_sign;
        inv_p0   <= in_invalid;
        dbz_p0   <= in_divbyzero;
        zero_p0  <= (in_frac == '0);
        rmode_p0 <= rmode;
        exp_p0   <= exp_n;
        frac_p0  <= in_frac << lz;
        info_p0  <= in_info;
      end
      if (flush) info_p0[0] <= 1'b0;
    end
  end

  // ---------------- stage 2: denormalise ----------------
  logic                   tiny_d1, lost_d1;
  logic signed [EW-1:0]   sh_raw;
  logic [SHW-1:0]         sh_d1;
  logic [QW-1:0]          dn_d1;

  always_comb begin
    tiny_d1 = (exp_p0 <= EXP_ZERO);
    sh_raw  = EXP_ONE - exp_p0;
    sh_d1   = '0;
    if (tiny_d1) sh_d1 = (sh_raw > SH_SAT) ? SHW'(SH_MAX) : sh_raw[SHW-1:0];
    dn_d1   = frac_p0 >> sh_d1;
    lost_d1 = |(frac_p0 & ~({QW{1'b1}} << sh_d1));
  end

  logic                   sign_p1, inv_p1, dbz_p1, zero_p1, tiny_p1, grd_p1, stk_p1;
  logic [1:0]             rmode_p1;
  logic signed [EW-1:0]   exp_p1;
  logic [MW-1:0]          mant_p1;
  logic [info_width-1:0]  info_p1;

  always_ff @(posedge clk) begin
    if (reset) begin
      sign_p1 <= 1'b0; inv_p1 <= 1'b0; dbz_p1 <= 1'b0; zero_p1 <= 1'b0;
      tiny_p1 <= 1'b0; grd_p1 <= 1'b0; stk_p1 <= 1'b0; rmode_p1 <= '0;
      exp_p1 <= '0; mant_p1 <= '0; info_p1 <= '0;
    end else begin
      if (!a_wait) begin
        sign_p1  <= sign_p0;
        inv_p1   <= inv_p0;
        dbz_p1   <= dbz_p0;
        zero_p1  <= zero_p0;
        tiny_p1  <= tiny_d1;
        rmode_p1 <= rmode_p0;
        exp_p1   <= tiny_d1 ? EXP_ZERO : exp_p0;
        mant_p1  <= dn_d1[QW-1 -: MW];
        grd_p1   <= dn_d1[QW-1-MW];
        stk_p1   <= (|dn_d1[QW-2-MW:0]) | lost_d1;
        info_p1  <= info_p0;
      end
      if (flush) info_p1[0] <= 1'b0;
    end
  end

  // ---------------- stage 3: round and pack ----------------
  logic                   inc_d2, carry_d2, ovf_d2, inx_d2;
  logic [MW:0]            mant_r;
  logic signed [EW-1:0]   exp_r;
  logic [frac_width-1:0]  frac_r;
  logic [RW-1:0]          res_d2;
  logic [FLAG_W-1:0]      flags_d2;

  always_comb begin
    inc_d2   = round_inc(rmode_p1, sign_p1, mant_p1[0], grd_p1, stk_p1);
    mant_r   = {1'b0, mant_p1} + {{MW{1'b0}}, inc_d2};
    carry_d2 = mant_r[MW];
    // A denormal whose rounding reaches the hidden bit becomes exponent 1.
    if (exp_p1 == EXP_ZERO) exp_r = {{(EW-1){1'b0}}, mant_r[MW-1]};
    else                    exp_r = exp_p1 + {{(EW-1){1'b0}}, carry_d2};
    frac_r   = carry_d2 ? mant_r[MW-1:1] : mant_r[MW-2:0];
    ovf_d2   = (exp_r >= EXP_OVF);
    inx_d2   = grd_p1 | stk_p1;
    res_d2   = {sign_p1, exp_r[exp_width-1:0], frac_r};
    flags_d2 = '0;
    if (inv_p1) begin
      res_d2 = DNAN;
      flags_d2[FLAG_INVALID] = 1'b1;
    end else if (dbz_p1) begin
      res_d2 = {sign_p1, {exp_width{1'b1}}, {frac_width{1'b0}}};
      flags_d2[FLAG_DIVBYZERO] = 1'b1;
    end else if (zero_p1) begin
      res_d2 = {sign_p1, {(RW-1){1'b0}}};
    end else if (ovf_d2) begin
      res_d2 = ovf_to_inf(rmode_p1, sign_p1)
             ? {sign_p1, {exp_width{1'b1}}, {frac_width{1'b0}}}
             : {sign_p1, {(exp_width-1){1'b1}}, 1'b0, {frac_width{1'b1}}};
      flags_d2[FLAG_OVERFLOW] = 1'b1;
      flags_d2[FLAG_INEXACT]  = 1'b1;
    end else begin
      flags_d2[FLAG_INEXACT]   = inx_d2;
      flags_d2[FLAG_UNDERFLOW] = tiny_p1 & inx_d2;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      result <= '0; flags <= '0; info_out <= '0;
    end else begin
      if (!a_wait) begin
        result   <= res_d2;
        flags    <= flags_d2;
        info_out <= info_p1;
      end
      if (flush) info_out[0] <= 1'b0;
    end
  end

endmodule

// File: tb/tb_f_divider_back.sv
// Bench for f_divider_back: directed vectors with literal expectations plus
// randomized streams checked against an arithmetic reference model.
module tb_f_divider_back;

  logic               clk = 1'b0;
  logic               reset, a_wait, flush;
  logic [1:0]         rmode;
  logic               in_sign;
  logic signed [12:0] in_exp;
  logic [107:0]       in_frac;
  logic [0:0]         in_info;
  logic               in_invalid, in_divbyzero;
  logic               stall_out;
  logic [63:0]        result;
  logic [0:0]         info_out;
  logic [4:0]         flags;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  f_divider_back dut (
    .clk(clk), .reset(reset), .a_wait(a_wait), .flush(flush), .rmode(rmode),
    .in_sign(in_sign), .in_exp(in_exp), .in_frac(in_frac), .in_info(in_info),
    .in_invalid(in_invalid), .in_divbyzero(in_divbyzero), .stall_out(stall_out),
    .result(result), .info_out(info_out), .flags(flags)
  );

  typedef struct {
    logic               s;
    logic signed [12:0] e;
    logic [107:0]       f;
    logic [1:0]         rm;
    logic               inv;
    logic               dbz;
  } vec_t;

  // Reference: value = f * 2^(e-1023-105). The result grid spacing is
  // 2^(max(E,1)-1075) where E is the unbounded biased exponent; drop d bits
  // of f to land on that grid and round on the remainder.
  function automatic logic [68:0] ref_div(input vec_t v);
    int p, e, eq, d, field;
    logic [255:0] big, m, rem, half;
    logic gt, eqh, nz, up, tiny, to_inf;
    logic [4:0] fl;
    logic [63:0] r;
    if (v.inv) return {64'h7FF7FFFFFFFFFFFF, 5'b10000};
    if (v.dbz) return {v.s, 11'h7FF, 52'h0, 5'b01000};
    if (v.f == 0) return {v.s, 63'h0, 5'b00000};
    p = 0;
    for (int i = 0; i < 108; i++) if (v.f[i]) p = i;
    e    = int'(v.e) + p - 105;
    tiny = (e <= 0);
    eq   = (e < 1) ? 1 : e;
    d    = eq - int'(v.e) + 53;
    big  = 256'(v.f);
    gt = 1'b0; eqh = 1'b0; nz = 1'b0;
    if (d <= 0) begin
      m = big << (-d);
    end else if (d >= 200) begin
      m = '0; nz = 1'b1;
    end else begin
      m    = big >> d;
      rem  = big & ((256'd1 << d) - 256'd1);
      half = 256'd1 << (d - 1);
      gt = (rem > half); eqh = (rem == half); nz = (rem != 0);
    end
    case (v.rm)
      2'd0:    up = gt | (eqh & m[0]);
      2'd1:    up = 1'b0;
      2'd2:    up = nz & ~v.s;
      default: up = nz & v.s;
    endcase
    m = m + 256'(up);
    if (m[53]) begin m = m >> 1; eq = eq + 1; end
    field = m[52] ? eq : 0;
    if (field >= 2047) begin
      to_inf = (v.rm == 2'd0) | ((v.rm == 2'd2) & ~v.s) | ((v.rm == 2'd3) & v.s);
      r  = to_inf ? {v.s, 11'h7FF, 52'h0} : {v.s, 11'h7FE, {52{1'b1}}};
      fl = 5'b00101;
    end else begin
      r  = {v.s, 11'(field), m[51:0]};
      fl = {3'b000, tiny & nz, nz};
    end
    return {r, fl};
  endfunction

  function automatic vec_t rand_vec();
    vec_t v;
    int ei;
    logic [127:0] r;
    r = {$urandom, $urandom, $urandom, $urandom};
    v.s  = 1'($urandom_range(0, 1));
    v.rm = 2'($urandom_range(0, 3));
    case ($urandom_range(0, 3))
      0:       ei = int'($urandom_range(0, 120)) - 60;
      1:       ei = 900 + int'($urandom_range(0, 250));
      2:       ei = 1990 + int'($urandom_range(0, 80));
      default: ei = int'($urandom);
    endcase
    v.e = 13'(ei);
    case ($urandom_range(0, 3))
      0:       v.f = r[107:0];
      1:       v.f = r[107:0] >> $urandom_range(0, 107);
      2:       v.f = 108'd1 << $urandom_range(0, 107);
      default: v.f = (108'd1 << 105) | (r[107:0] >> (56 + $urandom_range(0, 50)));
    endcase
    if ($urandom_range(0, 19) == 0) v.f = '0;
    v.inv = ($urandom_range(0, 19) == 0);
    v.dbz = ($urandom_range(0, 19) == 0);
    return v;
  endfunction

  task automatic drive_vec(input vec_t v);
    in_sign = v.s; in_exp = v.e; in_frac = v.f; rmode = v.rm;
    in_invalid = v.inv; in_divbyzero = v.dbz; in_info = 1'b1;
  endtask

  task automatic drive_idle();
    in_sign = 1'b0; in_exp = '0; in_frac = '0; rmode = '0;
    in_invalid = 1'b0; in_divbyzero = 1'b0; in_info = 1'b0;
  endtask

  // Drives one input and watches 8 cycles; reports the first valid output,
  // its latency in cycles and how many cycles info_out[0] was high.
  task automatic run_one(input vec_t v, output logic [63:0] r, output logic [4:0] fl,
                         output int lat, output int nvalid);
    r = 'x; fl = 'x; lat = -1; nvalid = 0;
    @(negedge clk);
    drive_vec(v);
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (k == 1) in_info = 1'b0;
      if (info_out[0]) begin
        nvalid++;
        if (lat < 0) begin lat = k; r = result; fl = flags; end
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; a_wait = 1'b0; flush = 1'b0;
    drive_idle();
    repeat (2) @(negedge clk);
    n_vec++;
    if (result !== 64'h0 || info_out !== 1'b0 || flags !== 5'h0) begin
      n_err++;
      $display("FAIL reset_state: result=%h info=%b flags=%b, want all zero", result, info_out, flags);
    end
    n_vec++;
    if (stall_out !== 1'b0) begin
      n_err++; $display("FAIL stall_idle: stall_out=%b want 0", stall_out);
    end
    reset = 1'b0;
  endtask

  task automatic test_directed();
    vec_t dv[10];
    logic [63:0] dr[10];
    logic [4:0]  df[10];
    logic [63:0] r;
    logic [4:0]  fl;
    int lat, nv;
    for (int i = 0; i < 10; i++) begin
      dv[i].s = 1'b0; dv[i].e = 13'sd1023; dv[i].f = 108'd1 << 105;
      dv[i].rm = 2'd0; dv[i].inv = 1'b0; dv[i].dbz = 1'b0;
    end
    dr[0] = 64'h3FF0000000000000; df[0] = 5'b00000;
    dv[1].f = (108'd1 << 105) | (108'd1 << 52);
    dr[1] = 64'h3FF0000000000000; df[1] = 5'b00001;
    dv[2].f = (108'd1 << 105) | (108'd1 << 52); dv[2].rm = 2'd2;
    dr[2] = 64'h3FF0000000000001; df[2] = 5'b00001;
    dv[3].e = 13'sd2100;
    dr[3] = 64'h7FF0000000000000; df[3] = 5'b00101;
    dv[4].e = 13'sd2100; dv[4].rm = 2'd1;
    dr[4] = 64'h7FEFFFFFFFFFFFFF; df[4] = 5'b00101;
    dv[5].e = 13'sd0;
    dr[5] = 64'h0008000000000000; df[5] = 5'b00000;
    dv[6].e = 13'sd0; dv[6].f = (108'd1 << 105) | 108'd1;
    dr[6] = 64'h0008000000000000; df[6] = 5'b00011;
    dv[7].inv = 1'b1; dv[7].dbz = 1'b1;
    dr[7] = 64'h7FF7FFFFFFFFFFFF; df[7] = 5'b10000;
    dv[8].dbz = 1'b1; dv[8].s = 1'b1;
    dr[8] = 64'hFFF0000000000000; df[8] = 5'b01000;
    dv[9].f = '0; dv[9].s = 1'b1;
    dr[9] = 64'h8000000000000000; df[9] = 5'b00000;
    for (int i = 0; i < 10; i++) begin
      run_one(dv[i], r, fl, lat, nv);
      n_vec++;
      if (r !== dr[i] || fl !== df[i]) begin
        n_err++;
        $display("FAIL directed_%0d: got %h flags %b, want %h flags %b", i, r, fl, dr[i], df[i]);
      end
      n_vec++;
      if (lat != 3 || nv != 1) begin
        n_err++;
        $display("FAIL timing_%0d: latency %0d valid-cycles %0d, want 3 and 1", i, lat, nv);
      end
    end
  endtask

  // mode 0: back-to-back with a 2-cycle stall after the third input;
  // mode 1: random stalls.
  task automatic test_stream(input int n, input int mode);
    logic [68:0] exp_q[$];
    logic [68:0] e;
    vec_t v;
    int sent = 0, got = 0, cyc = 0, stalls = 0, extra = 0;
    logic aw;
    while (got < n && cyc < n * 6 + 50) begin
      @(negedge clk);
      cyc++;
      n_vec++;
      if (stall_out !== a_wait) begin
        n_err++; $display("FAIL stall_out: got %b want %b", stall_out, a_wait);
      end
      if (mode == 0) begin
        aw = (sent == 3 && stalls < 2);
        if (aw) stalls++;
      end else begin
        aw = ($urandom_range(0, 4) == 0);
      end
      if (info_out[0] && !aw) begin
        n_vec++;
        if (exp_q.size() == 0) begin
          n_err++; $display("FAIL stream_extra: unexpected result %h", result);
        end else begin
          e = exp_q.pop_front();
          if ({result, flags} !== e) begin
            n_err++;
            $display("FAIL stream_%0d_%0d: got %h flags %b, want %h flags %b",
                     mode, got, result, flags, e[68:5], e[4:0]);
          end
        end
        got++;
      end
      a_wait = aw;
      if (!aw) begin
        if (sent < n) begin
          v = rand_vec(); drive_vec(v); exp_q.push_back(ref_div(v)); sent++;
        end else begin
          in_info = 1'b0;
        end
      end
    end
    a_wait = 1'b0;
    in_info = 1'b0;
    n_vec++;
    if (got != n || exp_q.size() != 0) begin
      n_err++;
      $display("FAIL stream_count_%0d: got %0d results, want %0d (%0d pending)", mode, got, n, exp_q.size());
    end
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (info_out[0]) extra++;
    end
    n_vec++;
    if (extra != 0) begin
      n_err++; $display("FAIL stream_dup_%0d: %0d extra valid cycles, want 0", mode, extra);
    end
  endtask

  task automatic test_flush();
    vec_t v;
    int seen;
    logic [63:0] r;
    logic [4:0] fl;
    logic [68:0] e;
    int lat, nv;
    for (int w = 0; w < 2; w++) begin
      seen = 0;
      @(negedge clk); v = rand_vec(); drive_vec(v);
      @(negedge clk); v = rand_vec(); drive_vec(v);
      @(negedge clk); v = rand_vec(); drive_vec(v);
      flush = 1'b1; a_wait = 1'(w);
      @(negedge clk);
      flush = 1'b0; a_wait = 1'b0; in_info = 1'b0;
      if (info_out[0]) seen++;
      for (int k = 0; k < 6; k++) begin
        @(negedge clk);
        if (info_out[0]) seen++;
      end
      n_vec++;
      if (seen != 0) begin
        n_err++; $display("FAIL flush_%0d: %0d valid outputs, want 0", w, seen);
      end
    end
    v = rand_vec(); v.inv = 1'b0; v.dbz = 1'b0;
    e = ref_div(v);
    run_one(v, r, fl, lat, nv);
    n_vec++;
    if ({r, fl} !== e || lat != 3) begin
      n_err++;
      $display("FAIL after_flush: got %h flags %b lat %0d, want %h flags %b lat 3", r, fl, lat, e[68:5], e[4:0]);
    end
  endtask

  task automatic test_reset_mid();
    vec_t v;
    int seen = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); v = rand_vec(); v.f = 108'd1 << 105; v.inv = 1'b1; drive_vec(v);
    end
    @(negedge clk);
    n_vec++;
    if (info_out[0] !== 1'b1) begin
      n_err++; $display("FAIL pre_reset_valid: info_out=%b want 1", info_out);
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0; in_info = 1'b0;
    n_vec++;
    if (result !== 64'h0 || info_out !== 1'b0 || flags !== 5'h0) begin
      n_err++;
      $display("FAIL reset_mid: result=%h info=%b flags=%b, want all zero", result, info_out, flags);
    end
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (info_out[0]) seen++;
    end
    n_vec++;
    if (seen != 0) begin
      n_err++; $display("FAIL reset_discard: %0d valid outputs after reset, want 0", seen);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_stream(12, 0);
    test_stream(400, 1);
    test_flush();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
